zc_conditioner: RTL and testbench
=================================

Name: zc_conditioner

Overview:
Input conditioning stage directly upstream of the trigger-pulse generator. Takes the raw grid zero-cross comparator output and produces a clean, debounced square wave (sig_out) that feeds the trigger generator's signal input. Also measures each half-period in 1 us ticks, checks it against a configured window, and reports lock and frequency-fault status. Upper control logic gates the trigger stage's enable with lock.

Parameters:
PRESCALE, 40, clk cycles per measurement tick (40 MHz clk -> 1 us tick)
CNT_W, 16, width of the period counter and period ports
FILT_W, 8, width of the filter length and filter counter

Ports:
clk  in  1  system clock, 40 MHz
rst  in  1  asynchronous reset, active-low
ctrl  in  8  [0] enable; [1] fault clear (level, sampled in S_FAULT); [7:2] reserved, ignored
raw_in  in  1  asynchronous zero-cross comparator output
filt_len  in  FILT_W  debounce length; quasi-static
per_min  in  CNT_W  minimum legal half-period, in ticks
per_max  in  CNT_W  maximum legal half-period, in ticks
sig_out  out  1  debounced square wave to the trigger stage
half_per  out  CNT_W  last measured half-period, in ticks
per_valid  out  1  one-clock pulse when half_per updates
lock  out  1  high in S_LOCK only
freq_fault  out  1  high in S_FAULT only
glitch_cnt  out  8  rejected-glitch count (optional feature)

Behaviour:
- Reset: all outputs 0, all counters 0, state S_IDLE, synchroniser flops 0.
- raw_in passes through a 2-flop synchroniser, giving sync.
- Filter (runs in every state):
  - sync != sig_out and fcnt < filt_len -> fcnt+1.
  - sync != sig_out and fcnt == filt_len -> sig_out toggles, fcnt <= 0.
  - sync == sig_out -> fcnt <= 0.
  - Latency from the first clk edge that samples the new raw level to the sig_out change: exactly filt_len+3 edges.
  - filt_len = 0 -> 3 edges.
- Edge: edge = sig_out XOR its 1-clock-delayed copy. Both polarities count.
- Prescaler: pcnt runs 0..PRESCALE-1. tick = (pcnt == PRESCALE-1). pcnt is cleared in S_IDLE.
- Period counter pc:
  - Increments on tick, saturating at all-ones.
  - On edge, pc <= 0. Edge wins over a coincident tick.
  - Held at 0 in S_IDLE.
- Measurement on an edge in S_ACQ or S_LOCK: half_per <= pc and per_valid = 1 in the same cycle as the pc clear. in_range = (per_min <= pc <= per_max), unsigned comparison.
- Timeout: pc > per_max with no edge.
- Lock requirement: LOCK_N = 4 consecutive in-range measurements, counted by good_cnt.
- States:
  - S_IDLE: outputs lock/fault 0, good_cnt 0. ctrl[0]=1 -> S_FIRST.
  - S_FIRST: first edge -> S_ACQ. No measurement, because the first period is partial.
  - S_ACQ: edge in range -> good_cnt+1; the 4th consecutive one -> S_LOCK. Edge out of range, or timeout -> good_cnt <= 0, stay in S_ACQ.
  - S_LOCK: edge out of range, or timeout -> S_FAULT.
  - S_FAULT: sticky. ctrl[1]=1 -> S_FIRST with good_cnt cleared.
- ctrl[0]=0 in any state -> S_IDLE on the next clock, with priority over all other transitions. half_per is retained.
- lock and freq_fault are registered decodes of the state.
- Reset mid-operation returns everything to the reset values immediately (asynchronous).

Optional Feature:
Macro ZC_GLITCH_CNT_EN.
- Defined: glitch_cnt increments, saturating at 255, whenever fcnt != 0 and sync returns equal to sig_out (a rejected glitch). Cleared in S_IDLE.
- Undefined: no counter logic is built; glitch_cnt is tied to 0.

Decomposition:
- Package zc_pkg holds:
  - state encoding, 3-bit: S_IDLE=0, S_FIRST=1, S_ACQ=2, S_LOCK=3, S_FAULT=4; unused codes -> S_IDLE.
  - LOCK_N = 4.
- Sub-module zc_debounce holds the synchroniser, filter counter, sig_out, edge detect, and the optional glitch counter.
- The top level keeps the prescaler, pc, range check, and FSM.

Test Plan:
- Debounce timing: filt_len=7, raw_in high for 5 clks -> sig_out stays 0 and glitch_cnt=1 (with macro). Raw high held for 20 clks -> sig_out rises exactly 10 clks after the first sampling edge.
- Acquire and lock: enable, per_min=9500, per_max=10500, 50 Hz raw (10 ms half) -> per_valid on edges 2..5 with half_per=10000±1; lock=1 on the clock after the 5th edge.
- Range fault: after lock, one half-period of 9 ms -> half_per=9000±1, freq_fault=1 and lock=0 on the next clock. ctrl[1]=1 -> S_FIRST, freq_fault=0.
- Signal loss: after lock, raw_in stuck -> freq_fault=1 once pc reaches 10501 ticks.
- Acquire reset: one bad period (8 ms) after 3 good ones -> good_cnt=0, and lock needs 4 further good periods.
- Enable drop and reset: ctrl[0]=0 while locked -> lock=0 next clock, pc=0, no per_valid. rst low mid-period -> all outputs 0 immediately.

Source files
------------

// File: rtl/zc_pkg.sv
// Shared definitions for the zero-cross conditioner: FSM state codes and lock depth.
package zc_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_FIRST = 3'd1;
  localparam state_t S_ACQ   = 3'd2;
  localparam state_t S_LOCK  = 3'd3;
  localparam state_t S_FAULT = 3'd4;

  localparam int LOCK_N = 4;
  localparam int GOOD_W = 3;

endpackage

// File: rtl/zc_debounce.sv
// Synchroniser, debounce filter, edge detect and optional glitch counter for the
// raw zero-cross input. Macro ZC_GLITCH_CNT_EN builds the rejected-glitch counter.
module zc_debounce #(
  parameter int FILT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              raw_in,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              clr_glitch,
  output logic              sig_out,
  output logic              sig_edge,
  output logic [7:0]        glitch_cnt
);

  logic              sync_a;
  logic              sync_b;
  logic              sig_d;
  logic [FILT_W-1:0] fcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      sig_out <= 1'b0;
      sig_d   <= 1'b0;
      fcnt    <= '0;
    end else begin
      sync_a <= raw_in;
      sync_b <= sync_a;
      sig_d  <= sig_out;
      if (sync_b != sig_out) begin
        // >= keeps the filter from stalling if filt_len is lowered mid-count
        if (fcnt >= filt_len) begin
          sig_out <= ~sig_out;
          fcnt    <= '0;
        end else begin
          fcnt <= fcnt + FILT_W'(1);
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  assign sig_edge = sig_out ^ sig_d;

`ifdef ZC_GLITCH_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      glitch_cnt <= '0;
    end else if (clr_glitch) begin
      glitch_cnt <= '0;
    end else if ((fcnt != '0) && (sync_b == sig_out) && (glitch_cnt != 8'hFF)) begin
      glitch_cnt <= glitch_cnt + 8'd1;
    end
  end
`else
  logic unused_clr_glitch;
  assign unused_clr_glitch = clr_glitch;
  assign glitch_cnt        = '0;
`endif

endmodule

// File: rtl/zc_conditioner.sv
// Zero-cross conditioner top: debounced square wave, half-period measurement in
// prescaled ticks, lock/fault FSM. Optional glitch counter via ZC_GLITCH_CNT_EN.
//
// state   | meaning
// S_IDLE  | disabled, counters held clear
// S_FIRST | waiting for first edge (partial period, not measured)
// S_ACQ   | measuring, counting consecutive in-range half-periods
// S_LOCK  | locked, any bad half-period or timeout faults
// S_FAULT | sticky fault until ctrl[1]
module zc_conditioner
  import zc_pkg::*;
#(
  parameter int PRESCALE = 40,
  parameter int CNT_W    = 16,
  parameter int FILT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ctrl,
  input  logic              raw_in,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [CNT_W-1:0]  per_min,
  input  logic [CNT_W-1:0]  per_max,
  output logic              sig_out,
  output logic [CNT_W-1:0]  half_per,
  output logic              per_valid,
  output logic              lock,
  output logic              freq_fault,
  output logic [7:0]        glitch_cnt
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  state_t              state;
  state_t              state_n;
  logic [GOOD_W-1:0]   good_cnt;
  logic [GOOD_W-1:0]   good_n;
  logic [PS_W-1:0]     pcnt;
  logic [CNT_W-1:0]    pc;
  logic                en;
  logic                fclr;
  logic                sig_edge;
  logic                tick;
  logic                in_range;
  logic                timeout;
  logic                measure;
  logic                hold_clr;
  logic                unused_ctrl;

  assign en          = ctrl[0];
  assign fclr        = ctrl[1];
  assign unused_ctrl = ^ctrl[7:2];

  zc_debounce #(.FILT_W(FILT_W)) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw_in),
    .filt_len   (filt_len),
    .clr_glitch (state == S_IDLE),
    .sig_out    (sig_out),
    .sig_edge   (sig_edge),
    .glitch_cnt (glitch_cnt)
  );

  // Dropping enable clears the timebase on the same clock the FSM returns to idle
  assign hold_clr = !en || (state == S_IDLE);
  assign tick     = (pcnt == PS_W'(PRESCALE - 1));
  assign in_range = (pc >= per_min) && (pc <= per_max);
  assign timeout  = !sig_edge && (pc > per_max);
  assign measure  = en && sig_edge && ((state == S_ACQ) || (state == S_LOCK));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt      <= '0;
      pc        <= '0;
      half_per  <= '0;
      per_valid <= 1'b0;
    end else begin
      per_valid <= measure;
      if (measure) begin
        half_per <= pc;
      end
      if (hold_clr || tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PS_W'(1);
      end
      if (hold_clr || sig_edge) begin
        pc <= '0;
      end else if (tick && (pc != '1)) begin
        pc <= pc + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_n = state;
    good_n  = good_cnt;
    if (!en) begin
      state_n = S_IDLE;
      good_n  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_n = S_FIRST;
          good_n  = '0;
        end
        S_FIRST: begin
          if (sig_edge) state_n = S_ACQ;
        end
        S_ACQ: begin
          if (sig_edge) begin
            if (in_range) begin
              good_n = good_cnt + GOOD_W'(1);
              if (good_cnt == GOOD_W'(LOCK_N - 1)) state_n = S_LOCK;
            end else begin
              good_n = '0;
            end
          end else if (timeout) begin
            good_n = '0;
          end
        end
        S_LOCK: begin
          if ((sig_edge && !in_range) || timeout) state_n = S_FAULT;
        end
        S_FAULT: begin
          if (fclr) begin
            state_n = S_FIRST;
            good_n  = '0;
          end
        end
        default: begin
          state_n = S_IDLE;
          good_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      good_cnt   <= '0;
      lock       <= 1'b0;
      freq_fault <= 1'b0;
    end else begin
      state      <= state_n;
      good_cnt   <= good_n;
      lock       <= (state_n == S_LOCK);
      freq_fault <= (state_n == S_FAULT);
    end
  end

endmodule

// File: tb/tb_zc_conditioner.sv
// Directed bench for zc_conditioner with a shortened tick (PRESCALE=4) and a
// half-period window of 95..105 ticks, nominal half-period 100 ticks.
module tb_zc_conditioner;

  localparam int P = 4;

`ifdef ZC_GLITCH_CNT_EN
  localparam int GEXP = 1;
`else
  localparam int GEXP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  ctrl = 8'h00;
  logic        raw_in = 1'b0;
  logic [7:0]  filt_len = 8'd7;
  logic [15:0] per_min = 16'd95;
  logic [15:0] per_max = 16'd105;
  logic        sig_out;
  logic [15:0] half_per;
  logic        per_valid;
  logic        lock;
  logic        freq_fault;
  logic [7:0]  glitch_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int len;
    bit pv;
    int hp;
    bit lk;
    bit ft;
    bit clr;
  } vec_t;

  vec_t tbl[16];

  zc_conditioner #(.PRESCALE(P), .CNT_W(16), .FILT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl       (ctrl),
    .raw_in     (raw_in),
    .filt_len   (filt_len),
    .per_min    (per_min),
    .per_max    (per_max),
    .sig_out    (sig_out),
    .half_per   (half_per),
    .per_valid  (per_valid),
    .lock       (lock),
    .freq_fault (freq_fault),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // four full half-periods then a fifth edge, sampled just after its measurement
  task automatic relock();
    for (int k = 0; k < 4; k++) begin
      raw_in = ~raw_in;
      repeat (100 * P) @(negedge clk);
    end
    raw_in = ~raw_in;
    repeat (11) @(negedge clk);
  endtask

  initial begin
    int  waited;
    int  m;
    int  pv_seen;
    bit  bad;

    //          len  pv  hp  lk ft clr
    tbl[0]  = '{100, 0,   0, 0, 0, 0};
    tbl[1]  = '{100, 1, 100, 0, 0, 0};
    tbl[2]  = '{100, 1, 100, 0, 0, 0};
    tbl[3]  = '{ 80, 1, 100, 0, 0, 0};
    tbl[4]  = '{100, 1,  80, 0, 0, 0};
    tbl[5]  = '{100, 1, 100, 0, 0, 0};
    tbl[6]  = '{100, 1, 100, 0, 0, 0};
    tbl[7]  = '{100, 1, 100, 0, 0, 0};
    tbl[8]  = '{ 90, 1, 100, 1, 0, 0};
    tbl[9]  = '{100, 1,  90, 0, 1, 0};
    tbl[10] = '{100, 0,   0, 0, 1, 1};
    tbl[11] = '{100, 0,   0, 0, 0, 0};
    tbl[12] = '{100, 1, 100, 0, 0, 0};
    tbl[13] = '{100, 1, 100, 0, 0, 0};
    tbl[14] = '{100, 1, 100, 0, 0, 0};
    tbl[15] = '{100, 1, 100, 1, 0, 0};

    #12;
    check("reset_outputs", {sig_out, half_per, per_valid, lock, freq_fault, glitch_cnt}, 0);
    @(negedge clk);
    rst  = 1'b1;
    ctrl = 8'h01;
    repeat (3) @(negedge clk);

    // short pulse: 5 clocks high is rejected by a 7-long filter
    raw_in = 1'b1;
    repeat (5) @(negedge clk);
    raw_in = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (sig_out) bad = 1'b1;
    end
    check("glitch_sig_out", bad, 0);
    check("glitch_cnt", glitch_cnt, GEXP);

    raw_in = 1'b1;
    repeat (9) @(negedge clk);
    check("rise_edge9", sig_out, 0);
    @(negedge clk);
    check("rise_edge10", sig_out, 1);

    ctrl = 8'h00;
    repeat (3) @(negedge clk);
    ctrl = 8'h01;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      raw_in = ~raw_in;
      repeat (11) @(negedge clk);
      check($sformatf("v%0d_per_valid", i), per_valid, tbl[i].pv);
      if (tbl[i].pv) check_rng($sformatf("v%0d_half_per", i), half_per, tbl[i].hp - 1, tbl[i].hp + 1);
      check($sformatf("v%0d_lock", i), lock, tbl[i].lk);
      check($sformatf("v%0d_freq_fault", i), freq_fault, tbl[i].ft);
      waited = 11;
      if (tbl[i].clr) begin
        ctrl[1] = 1'b1;
        @(negedge clk);
        ctrl[1] = 1'b0;
        waited++;
        check($sformatf("v%0d_clr_fault", i), freq_fault, 0);
        check($sformatf("v%0d_clr_lock", i), lock, 0);
      end
      if (i < 15) repeat (tbl[i].len * P - waited) @(negedge clk);
    end

    // signal loss: fault once pc passes per_max with no edge
    m = 0;
    while (!freq_fault && m < 600) begin
      @(negedge clk);
      m++;
    end
    check_rng("loss_fault_delay", m, 105 * P + 2, 106 * P + 1);
    check("loss_lock", lock, 0);

    ctrl[1] = 1'b1;
    @(negedge clk);
    ctrl[1] = 1'b0;
    check("loss_clear_fault", freq_fault, 0);

    relock();
    check("relock1_lock", lock, 1);

    repeat (20) @(negedge clk);
    ctrl[0] = 1'b0;
    @(negedge clk);
    check("drop_lock", lock, 0);
    check("drop_per_valid", per_valid, 0);
    check("drop_pc", dut.pc, 0);
    check_rng("drop_half_per_kept", half_per, 99, 101);
    raw_in  = ~raw_in;
    pv_seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (per_valid) pv_seen++;
    end
    check("drop_no_measure", pv_seen, 0);

    ctrl[0] = 1'b1;
    @(negedge clk);
    relock();
    check("relock2_lock", lock, 1);

    repeat (30) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_outputs", {sig_out, half_per, per_valid, lock, freq_fault, glitch_cnt}, 0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
